// File: rtl/muldiv_seq.sv
// Iterative MIPS multiply/divide unit owning HI/LO: one bit per cycle, then a
// single sign-fix cycle before the result is committed.
module muldiv_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t             state_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [WIDTH-1:0]   acc_hi_reg;   // product high half, or remainder
   logic [WIDTH-1:0]   acc_lo_reg;   // product low half/multiplier, or quotient/dividend
   logic [WIDTH-1:0]   operand_reg;  // multiplicand or divisor
   logic               is_div_reg;
   logic               sign_a_reg;
   logic               sign_b_reg;
   logic               dbz_reg;
   logic               busy_reg;
   logic               done_reg;
   logic               dbz_out_reg;
   logic [WIDTH-1:0]   hi_reg;
   logic [WIDTH-1:0]   lo_reg;

   logic               accept;
   logic               sgn_a;
   logic               sgn_b;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_trial;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign accept = start && (state_reg == IDLE || state_reg == DONE);
   assign sgn_a  = op[0] & A[WIDTH-1];
   assign sgn_b  = op[0] & B[WIDTH-1];
   assign abs_a  = sgn_a ? -A : A;
   assign abs_b  = sgn_b ? -B : B;

   always_comb begin
      mul_sum   = {1'b0, acc_hi_reg};
      if (acc_lo_reg[0])
         mul_sum = {1'b0, acc_hi_reg} + {1'b0, operand_reg};
      div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
      div_trial = div_shift - {1'b0, operand_reg};
   end

   // Sign correction; a zero divisor yields all-ones quotient and the dividend as remainder.
   always_comb begin
      prod_fix = {acc_hi_reg, acc_lo_reg};
      if (sign_a_reg ^ sign_b_reg)
         prod_fix = -{acc_hi_reg, acc_lo_reg};
      quo_fix = acc_lo_reg;
      if (dbz_reg)
         quo_fix = '1;
      else if (sign_a_reg ^ sign_b_reg)
         quo_fix = -acc_lo_reg;
      rem_fix = sign_a_reg ? -acc_hi_reg : acc_hi_reg;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         acc_hi_reg  <= '0;
         acc_lo_reg  <= '0;
         operand_reg <= '0;
         is_div_reg  <= 1'b0;
         sign_a_reg  <= 1'b0;
         sign_b_reg  <= 1'b0;
         dbz_reg     <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         dbz_out_reg <= 1'b0;
         hi_reg      <= '0;
         lo_reg      <= '0;
      end else begin
         done_reg <= 1'b0;
         if (!busy_reg) begin
            if (hi_we) hi_reg <= wdata;
            if (lo_we) lo_reg <= wdata;
         end
         case (state_reg)
            IDLE, DONE: begin
               if (accept) begin
                  state_reg   <= CALC;
                  busy_reg    <= 1'b1;
                  cnt_reg     <= '0;
                  is_div_reg  <= op[1];
                  sign_a_reg  <= sgn_a;
                  sign_b_reg  <= sgn_b;
                  dbz_reg     <= op[1] && (B == '0);
                  dbz_out_reg <= 1'b0;
                  acc_hi_reg  <= '0;
                  acc_lo_reg  <= op[1] ? abs_a : abs_b;
                  operand_reg <= op[1] ? abs_b : abs_a;
               end else begin
                  state_reg <= IDLE;
               end
            end
            CALC: begin
               if (is_div_reg) begin
                  if (!div_trial[WIDTH]) begin
                     acc_hi_reg <= div_trial[WIDTH-1:0];
                     acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], 1'b1};
                  end else begin
                     acc_hi_reg <= div_shift[WIDTH-1:0];
                     acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  acc_hi_reg <= mul_sum[WIDTH:1];
                  acc_lo_reg <= {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
               end
               cnt_reg <= cnt_reg + 1'b1;
               if (cnt_reg == CNT_W'(WIDTH-1))
                  state_reg <= FIX;
            end
            FIX: begin
               state_reg   <= DONE;
               busy_reg    <= 1'b0;
               done_reg    <= 1'b1;
               dbz_out_reg <= dbz_reg;
               if (is_div_reg) begin
                  hi_reg <= rem_fix;
                  lo_reg <= quo_fix;
               end else begin
                  hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_reg <= prod_fix[WIDTH-1:0];
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign busy        = busy_reg;
   assign done        = done_reg;
   assign div_by_zero = dbz_out_reg;
   assign hi          = hi_reg;
   assign lo          = lo_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: hand-computed results, latency and handshake checks.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a_in = '0;
   logic [31:0] b_in = '0;
   logic        hi_we = 1'b0;
   logic        lo_we = 1'b0;
   logic [31:0] wdata = '0;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   int checks = 0;
   int passes = 0;

   localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

   muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(a_in), .B(b_in),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp)
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      else begin
         passes++;
         $display("ok   %s: %h", tag, obs);
      end
   endtask

   // Called at a negedge; returns at the negedge after the start edge.
   task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; op = o; a_in = a; b_in = b;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; op = 2'b00; a_in = 32'hDEAD_BEEF; b_in = 32'h0BAD_F00D;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (!done && n < 100);
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input logic edbz);
      int n;
      launch(o, a, b);
      chk({tag, " busy"}, 32'(busy), 32'd1);
      wait_done(n);
      chk({tag, " latency"}, n, 33);
      chk({tag, " hi"}, hi, eh);
      chk({tag, " lo"}, lo, el);
      chk({tag, " dbz"}, 32'(div_by_zero), 32'(edbz));
      chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int n;
      logic seen_done;

      #12;
      chk("reset hi", hi, 32'h0);
      chk("reset lo", lo, 32'h0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset dbz", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // MT writes in IDLE
      lo_we = 1'b1; wdata = 32'h1357_9BDF;
      @(negedge clk);
      lo_we = 1'b0;
      chk("mtlo idle", lo, 32'h1357_9BDF);
      hi_we = 1'b1; wdata = 32'h2468_ACE0;
      @(negedge clk);
      hi_we = 1'b0;
      chk("mthi idle", hi, 32'h2468_ACE0);

      // Reset during CALC aborts without a result
      launch(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort hi", hi, 32'h0);
      chk("abort lo", lo, 32'h0);
      chk("abort busy", 32'(busy), 32'd0);
      seen_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      chk("abort no done", 32'(seen_done), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op("multu max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      @(negedge clk);
      run_op("mult -7*3", MULT, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      @(negedge clk);
      run_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      @(negedge clk);
      run_op("divu 100/7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      @(negedge clk);
      run_op("div min/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
      @(negedge clk);
      run_op("divu by0", DIVU, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
      @(negedge clk);

      // Flag clears on the next accepted start; stray start and MTHI while busy are ignored
      launch(MULTU, 32'd6, 32'd7);
      chk("dbz cleared", 32'(div_by_zero), 32'd0);
      repeat (4) @(negedge clk);
      start = 1'b1; op = DIVU; a_in = 32'd9; b_in = 32'd0;
      hi_we = 1'b1; wdata = 32'hAAAA_5555;
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0;
      chk("mthi busy hi", hi, 32'h0000_1234);
      wait_done(n);
      chk("stray start latency", n, 28);
      chk("stray start hi", hi, 32'h0);
      chk("stray start lo", lo, 32'd42);
      chk("stray start dbz", 32'(div_by_zero), 32'd0);

      // Back-to-back start while in DONE
      launch(DIVU, 32'd1000, 32'd33);
      chk("b2b busy", 32'(busy), 32'd1);
      wait_done(n);
      chk("b2b latency", n, 33);
      chk("b2b hi", hi, 32'd10);
      chk("b2b lo", lo, 32'd30);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU. Owns the HI/LO register pair; serves MFHI/MFLO reads and MTHI/MTLO writes.
- Replaces the single-cycle combinational multiply/divide path of the ALU with a 1-bit-per-cycle iterative shift-add/restoring-subtract datapath under FSM control.
- Sits beside the ALU in EX; the pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch operation; sampled only in IDLE or DONE
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- A  in  WIDTH  rs operand: multiplicand or dividend
- B  in  WIDTH  rt operand: multiplier or divisor
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  high in CALC and FIX
- done  out  1  one-cycle pulse; HI/LO valid
- div_by_zero  out  1  valid with done; held until next accepted start
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0; counter and internal working registers cleared. Reset asserted mid-operation aborts immediately; no HI/LO update.
- States: IDLE, CALC, FIX, DONE.
  - IDLE/DONE --start--> CALC.
  - CALC --counter==WIDTH-1--> FIX.
  - FIX --> DONE (always).
  - DONE --!start--> IDLE.
- Operand capture at start edge:
  - Signed ops (MULT, DIV): store |A|, |B| and the operand signs.
  - Unsigned ops (MULTU, DIVU): store A and B raw.
  - counter=0; div_by_zero=0.
- CALC, one iteration per edge, exactly WIDTH edges:
  - Multiply: 2*WIDTH product register; add multiplicand when the current multiplier LSB is 1, then shift right.
  - Divide: restoring division; shift remainder/quotient left, trial subtract divisor, keep the result if non-negative and set the quotient bit.
- FIX (1 edge), sign correction:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
- HI/LO commit on the FIX->DONE edge:
  - Multiply: HI=product[63:32], LO=product[31:0].
  - Divide: HI=remainder, LO=quotient.
- Latency: start sampled at edge E0; done=1 in the cycle after edge E0+WIDTH+1 (E33 for WIDTH=32); back-to-back start in DONE is accepted. busy=1 from after E0 until after E32.
- Divide by zero (B==0, op[1]=1): full latency still taken. Result HI=A (original, unsigned view), LO=all ones. div_by_zero=1 together with done.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0; no flag.
- start while busy: ignored. op/A/B are don't-care after the capture edge.
- MTHI/MTLO: hi_we/lo_we write wdata on the edge when busy=0.
  - Ignored while busy.
  - A write coincident with a DONE-state start is applied and later overwritten by the new result.
  - A write on the same edge as the FIX commit is dropped, because busy=1.
- hi/lo change only on reset, commit, or an MT write.

Test Plan:
- Reset mid-CALC: start MULTU, deassert rst_n at cycle 10 -> hi=lo=0, busy=0, state IDLE; no done pulse.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> done exactly 33 edges after start edge; HI=0xFFFFFFFE, LO=0x00000001; busy low with done.
- MULT A=-7 (0xFFFFFFF9), B=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=100, B=7 -> LO=14, HI=2. DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0, div_by_zero=0.
- DIVU A=0x1234, B=0 -> HI=0x1234, LO=0xFFFFFFFF, div_by_zero=1 with done; flag clears on next start.
- Handshake:
  - start pulsed during CALC -> ignored; result unchanged.
  - hi_we with wdata=0xAAAA5555 while busy -> hi unchanged.
  - lo_we in IDLE -> lo=wdata next cycle.
  - start asserted in DONE -> second result delivered 33 edges later; no IDLE cycle between the two operations.
